// File: rtl/bru_pkg.sv
// Shared types for the branch resolve unit: tracking-queue entry, FSM states, PC step.
package bru_pkg;

    localparam logic [63:0] PC_STEP = 64'd4;

    typedef struct packed {
        logic [63:0] pc;
        logic        taken;
        logic [63:0] target;
    } bru_entry_t;

    typedef enum logic {
        RUN,
        FLUSH
    } bru_state_t;

endpackage

// File: rtl/bru_fifo.sv
// In-order circular tracking queue with extra-MSB pointers and a synchronous clear
// that takes priority over push/pop in the same cycle.
module bru_fifo
    import bru_pkg::*;
#(
    parameter int  DEPTH = 4,
    parameter type T     = bru_entry_t
) (
    input  logic clk,
    input  logic arst_n,
    input  logic clear,
    input  logic push,
    input  logic pop,
    input  T     wdata,
    output T     rdata,
    output logic full,
    output logic empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    T              mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
        end
    end

    // Storage needs no reset: an entry is only ever read after it has been written.
    always_ff @(posedge clk) begin
        if (do_push && !clear) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// Retires resolved branches against the predicted-branch queue, trains the predictor
// and issues one-cycle flushes on mispredicts. Optional counters: define BRU_STATS_EN.
module branch_resolve_unit
    import bru_pkg::*;
#(
    parameter int LOWER = 5,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             arst_n,
    input  logic             pred_valid,
    input  logic [63:0]      pred_pc,
    input  logic             pred_taken,
    input  logic [63:0]      pred_target,
    output logic             pred_ready,
    input  logic             res_valid,
    input  logic             res_taken,
    input  logic [63:0]      res_target,
    output logic             res_ready,
    output logic             upd_en,
    output logic [LOWER-1:0] upd_addr,
    output logic             upd_taken,
    output logic             flush,
    output logic [63:0]      redirect_pc
`ifdef BRU_STATS_EN
    ,
    output logic [31:0]      stat_branches,
    output logic [31:0]      stat_mispredicts
`endif
);

    bru_state_t state;
    bru_entry_t head;
    bru_entry_t new_entry;
    logic       q_full;
    logic       q_empty;
    logic       do_push;
    logic       do_pop;
    logic       mispredict;

    assign new_entry  = '{pc: pred_pc, taken: pred_taken, target: pred_target};
    assign pred_ready = !q_full && (state == RUN);
    assign res_ready  = !q_empty && (state == RUN);
    assign do_push    = pred_valid && pred_ready;
    assign do_pop     = res_valid && res_ready;

    // A not-taken prediction carries no meaningful target, so targets only matter when both sides say taken.
    assign mispredict = do_pop &&
                        ((res_taken != head.taken) ||
                         (res_taken && head.taken && (res_target != head.target)));

    bru_fifo #(
        .DEPTH (DEPTH),
        .T     (bru_entry_t)
    ) u_fifo (
        .clk    (clk),
        .arst_n (arst_n),
        .clear  (mispredict),
        .push   (do_push),
        .pop    (do_pop),
        .wdata  (new_entry),
        .rdata  (head),
        .full   (q_full),
        .empty  (q_empty)
    );

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state       <= RUN;
            upd_en      <= 1'b0;
            upd_addr    <= '0;
            upd_taken   <= 1'b0;
            flush       <= 1'b0;
            redirect_pc <= '0;
        end else begin
            upd_en <= do_pop;
            flush  <= mispredict;
            if (do_pop) begin
                upd_addr  <= head.pc[LOWER+1:2];
                upd_taken <= res_taken;
            end
            if (mispredict) begin
                redirect_pc <= res_taken ? res_target : (head.pc + PC_STEP);
            end
            case (state)
                RUN:   if (mispredict) state <= FLUSH;
                FLUSH: state <= RUN;
            endcase
        end
    end

`ifdef BRU_STATS_EN
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            stat_branches    <= '0;
            stat_mispredicts <= '0;
        end else begin
            if (do_pop)     stat_branches    <= stat_branches + 32'd1;
            if (mispredict) stat_mispredicts <= stat_mispredicts + 32'd1;
        end
    end
`endif

endmodule
